// File: rtl/contador_pkg.sv
// Shared definitions for the contador_display counter and its helpers.
// Holds the counter limits, the run-state encoding and the load saturation helper.
package contador_pkg;

    localparam logic [3:0] HEX_MAX = 4'hF;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic {
        PARADO   = 1'b0,
        CONTANDO = 1'b1
    } estado_t;

    // Clamp a load value to the counter's maximum so BCD mode never holds a non-decimal digit
    function automatic logic [3:0] satura_carga(input logic [3:0] valor, input logic [3:0] max_v);
        return (valor > max_v) ? max_v : valor;
    endfunction

endpackage

// File: rtl/contador_display_detector_borda.sv
// Rising-edge detector for the (already debounced) start/stop button.
// The previous sample lives in btn_q, so a held button yields a single rise.
module detector_borda (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic btn_q;

    // Remember last cycle's input level
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= in;
        end
    end

    assign rise = in & ~btn_q;

endmodule

// File: rtl/contador_display.sv
// Prescaled up/down 4-bit counter with start/stop button, parallel load and
// carry/borrow pulse, feeding a 7-segment decoder through bits A (MSB) .. D (LSB).
// Optional feature macro: CONTADOR_BCD_EN selects a decimal (0..9) counter with
// saturating load; without it the counter runs over the full hex range.
module contador_display
    import contador_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] din,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       carry,
    output logic       rodando
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

`ifdef CONTADOR_BCD_EN
    localparam logic [3:0] CNT_MAX = BCD_MAX;
`else
    localparam logic [3:0] CNT_MAX = HEX_MAX;
`endif

    estado_t          state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       value_q, value_d;
    logic             carry_q, carry_d;
    logic             rise;
    logic             step;
    logic [3:0]       load_val;

    detector_borda u_detector_borda (
        .clk  (clk),
        .rst  (rst),
        .in   (btn),
        .rise (rise)
    );

`ifdef CONTADOR_BCD_EN
    assign load_val = satura_carga(din, CNT_MAX);
`else
    assign load_val = din;
`endif

    // A step is due on the last prescaler cycle of an interval while running
    assign step = (state_q == CONTANDO) && (div_q == DIV_LAST);

    // Run-state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PARADO;
        end else begin
            state_q <= state_d;
        end
    end

    // Each button rise flips between stopped and counting; load leaves it alone
    always_comb begin
        state_d = state_q;
        if (rise) begin
            state_d = (state_q == PARADO) ? CONTANDO : PARADO;
        end
    end

    // Run indicator comes straight from the state register
    always_comb begin
        rodando = (state_q == CONTANDO);
    end

    // Prescaler and counter value: load wins over a coincident step
    always_comb begin
        div_d   = div_q + 1'b1;
        value_d = value_q;
        carry_d = 1'b0;
        // Any start, stop, load or interval end restarts the interval count
        if (load || (state_q == PARADO) || rise || (div_q == DIV_LAST)) begin
            div_d = '0;
        end
        if (load) begin
            value_d = load_val;
        end else if (step) begin
            if (up) begin
                if (value_q == CNT_MAX) begin
                    value_d = 4'd0;
                    carry_d = 1'b1;
                end else begin
                    value_d = value_q + 4'd1;
                end
            end else begin
                if (value_q == 4'd0) begin
                    value_d = CNT_MAX;
                    carry_d = 1'b1;
                end else begin
                    value_d = value_q - 4'd1;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            value_q <= 4'd0;
            carry_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            value_q <= value_d;
            carry_q <= carry_d;
        end
    end

    assign {A, B, C, D} = value_q;
    assign carry        = carry_q;

endmodule

// File: tb/tb_contador_display.sv
// Self-checking bench for contador_display: directed scenarios followed by
// randomized stimulus, all compared against a cycle-level behavioural model.
module tb_contador_display;

    localparam int CLK_DIV = 4;
`ifdef CONTADOR_BCD_EN
    localparam int MAXV = 9;
`else
    localparam int MAXV = 15;
`endif

    logic       clk = 1'b0;
    logic       rst, btn, up, load;
    logic [3:0] din;
    logic       A, B, C, D, carry, rodando;

    contador_display #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .up      (up),
        .load    (load),
        .din     (din),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .carry   (carry),
        .rodando (rodando)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_val;
    int m_ticks;
    bit m_carry;
    bit m_run;
    bit m_btn_prev;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the reference behaviour, from the inputs seen at the edge
    task automatic model_update(input bit r, input bit b, input bit u, input bit l, input int d);
        bit rise_now;
        bit stepping;
        if (r) begin
            m_val = 0; m_ticks = 0; m_carry = 0; m_run = 0; m_btn_prev = 0;
        end else begin
            rise_now   = b && !m_btn_prev;
            m_btn_prev = b;
            stepping   = 0;
            if (m_run) begin
                m_ticks++;
                if (m_ticks == CLK_DIV) stepping = 1;
            end
            m_carry = 0;
            if (l) begin
                m_val   = (d > MAXV) ? MAXV : d;
                m_ticks = 0;
            end else if (stepping) begin
                if (u) begin
                    m_carry = (m_val == MAXV);
                    m_val   = (m_val + 1) % (MAXV + 1);
                end else begin
                    m_carry = (m_val == 0);
                    m_val   = (m_val + MAXV) % (MAXV + 1);
                end
                m_ticks = 0;
            end
            if (stepping && !l) m_ticks = 0;
            if (rise_now) begin
                m_run   = !m_run;
                m_ticks = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, advance model, compare just after the edge
    task automatic cycle(input bit r, input bit b, input bit u, input bit l, input logic [3:0] d);
        rst = r; btn = b; up = u; load = l; din = d;
        @(posedge clk);
        model_update(r, b, u, l, int'(d));
        #1;
        check_eq("abcd", {4'b0, A, B, C, D}, 8'(m_val));
        check_eq("carry", {7'b0, carry}, {7'b0, m_carry});
        check_eq("rodando", {7'b0, rodando}, {7'b0, m_run});
        $display("t=%0t rst=%0b btn=%0b up=%0b load=%0b din=%h -> abcd=%b carry=%0b rodando=%0b",
                 $time, r, b, u, l, d, {A, B, C, D}, carry, rodando);
    endtask

    task automatic idle(input int n, input bit u);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, u, 1'b0, 4'h0);
    endtask

    logic [3:0] held;

    initial begin
        m_val = 0; m_ticks = 0; m_carry = 0; m_run = 0; m_btn_prev = 0;

        // Reset for two cycles, then idle with btn low
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        check_eq("reset_abcd", {4'b0, A, B, C, D}, 8'd0);
        check_eq("reset_rodando", {7'b0, rodando}, 8'd0);
        idle(5, 1'b1);
        check_eq("idle_abcd", {4'b0, A, B, C, D}, 8'd0);

        // Start counting up: steps at t0+4, t0+8, t0+12
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        check_eq("start_rodando", {7'b0, rodando}, 8'd1);
        idle(3, 1'b1);
        check_eq("pre_first_step", {4'b0, A, B, C, D}, 8'd0);
        idle(1, 1'b1);
        check_eq("first_step", {4'b0, A, B, C, D}, 8'd1);
        idle(8, 1'b1);
        check_eq("third_step", {4'b0, A, B, C, D}, 8'd3);

        // Wrap upward from MAX-1
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'(MAXV - 1));
        idle(4, 1'b1);
        check_eq("wrap_max", {4'b0, A, B, C, D}, 8'(MAXV));
        check_eq("wrap_max_carry", {7'b0, carry}, 8'd0);
        idle(4, 1'b1);
        check_eq("wrap_zero", {4'b0, A, B, C, D}, 8'd0);
        check_eq("wrap_carry", {7'b0, carry}, 8'd1);
        idle(1, 1'b1);
        check_eq("carry_one_cycle", {7'b0, carry}, 8'd0);

        // Load of 4'hC: saturates in BCD mode, loads as-is in hex mode
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'hC);
        check_eq("load_c", {4'b0, A, B, C, D}, (MAXV == 9) ? 8'd9 : 8'd12);

        // Borrow downward from 0
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        idle(4, 1'b0);
        check_eq("borrow_val", {4'b0, A, B, C, D}, 8'(MAXV));
        check_eq("borrow_carry", {7'b0, carry}, 8'd1);

        // Stop two cycles after a step, hold for 20 cycles
        idle(1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        held = {A, B, C, D};
        check_eq("stop_rodando", {7'b0, rodando}, 8'd0);
        idle(20, 1'b0);
        check_eq("stop_hold", {4'b0, A, B, C, D}, {4'b0, held});

        // Restart: next step exactly CLK_DIV edges later
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        idle(3, 1'b0);
        check_eq("restart_pre", {4'b0, A, B, C, D}, {4'b0, held});
        idle(1, 1'b0);
        check_eq("restart_step", {4'b0, A, B, C, D}, 8'(held - 4'd1));

        // Button held high for 10 cycles toggles only once (stop)
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        check_eq("held_btn", {7'b0, rodando}, 8'd0);
        idle(1, 1'b1);

        // Restart, then load 5 exactly on the cycle a step would land
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        idle(3, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h5);
        check_eq("load_vs_step", {4'b0, A, B, C, D}, 8'd5);
        idle(4, 1'b1);
        check_eq("after_load_step", {4'b0, A, B, C, D}, 8'd6);

        // Reset mid-run clears everything at that edge
        idle(2, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        check_eq("rst_abcd", {4'b0, A, B, C, D}, 8'd0);
        check_eq("rst_rodando", {7'b0, rodando}, 8'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0),
                  4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
